sigmoid: RTL and testbench
==========================

// Module: sigmoid
// PURPOSE
//   Vectorised logistic activation for the neural-net datapath: y[i] ~= 1/(1+exp(-x[i])) on N packed
//   IEEE-754 single-precision lanes. Uses the PLAN piecewise-linear approximation in Q8.24 fixed point.
//   Lanes are processed sequentially, one per clock. The block sits after each layer's accumulator.
// PARAMETERS
//   S  32  lane width in bits; only 32 (IEEE-754 binary32) is supported
//   N  2   number of lanes; lane i = x[S*i +: S], result in y[S*i +: S]
// PORTS
//   clk    in   1    single clock, all state on rising edge
//   rst_n  in   1    reset, asynchronous, active-low
//   start  in   1    request: latch x and compute
//   x      in   S*N  packed float inputs
//   y      out  S*N  packed float results, valid while done=1
//   done   out  1    high from result-complete until the next accepted request
// BEHAVIOUR
//   Reset (rst_n=0): y=0, done=0, lane index=0, state=LOAD. Asynchronous assert, no clock needed.
//   FSM states:
//     LOAD: the first rising edge after rst_n releases is an implicit request,
//           whether or not start is high. On that edge: latch x, set idx=0, go to CALC.
//     CALC: each edge computes lane idx, writes y lane idx, and increments idx.
//           After lane N-1: done<=1, go to DONE.
//     DONE: hold y and done. start=1 at an edge latches new x, clears done, idx=0, goes to CALC.
//   start is ignored in CALC. It is a don't-care while rst_n=0.
//   Reset mid-computation aborts immediately and returns to LOAD.
//   Latency: done is high after the Nth edge following the accepting edge.
//   Lanes are updated in place, so y is undefined while done=0.
//   Per-lane arithmetic:
//     Split x into sign s, exponent e (unbiased), mantissa m = {1,frac}. m has 24 bits.
//     Compute a = |x| in Q8.24, with truncation:
//       a = m << (e+1) for e>=-1; a = m >> -(e+1) otherwise.
//       exp field 0 (zero/denormal) -> a=0. e<=-26 -> a=0.
//       e>=3 or exp field 255 (Inf/NaN) -> saturate to the top segment.
//     Segment table (constants in Q.24):
//       a >= 5.0            -> p = 1.0
//       2.375 <= a < 5.0    -> p = (a>>5) + 0.84375
//       1.0   <= a < 2.375  -> p = (a>>3) + 0.625
//       a < 1.0             -> p = (a>>2) + 0.5
//     Sign: s=0 -> r=p; s=1 -> r = 1.0 - p (Q.24 subtraction).
//     Fixed to float: r=0 -> +0.0 (32'h0). Otherwise the leading one at bit k gives exponent 127+k-24.
//       Mantissa is the bits below the leading one, left-aligned to 23 bits, truncated.
//       The sign of the result is always 0.
//   NaN input is handled by its sign bit like Inf (+ -> 1.0, - -> 0.0).
// TESTING
//   Reset with x={32'hc0733333,32'h40a00000}, start pulsed during reset, release
//     -> done after 2 edges; y={32'h3D1999A0,32'h3F800000} (-3.8->0.0375, 5.0->1.0).
//   Reset with x={32'h00000000,32'h40a00000} -> y={32'h3F000000,32'h3F800000}.
//   From DONE, start with x={32'hBF800000,32'h3F800000}
//     -> done drops next edge, returns 2 edges later; y={32'h3E800000,32'h3F400000}.
//   x={32'hC0A00000,32'h3F000000} -> y={32'h00000000,32'h3F200000};
//     also check 32'h7F800000->32'h3F800000 and 32'hFF800000->32'h00000000.
//   Assert rst_n=0 mid-CALC -> done=0, y=0 at once;
//     after release, a fresh computation completes with correct values.
//   start pulsed during CALC -> ignored; exactly one done rise per accepted request.

Source files
------------

// File: rtl/sigmoid.sv
// Sequential lane-by-lane logistic activation on packed binary32 floats,
// using a piecewise-linear approximation evaluated in Q8.24 fixed point.
module sigmoid #(
  parameter int unsigned S = 32,
  parameter int unsigned N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [S*N-1:0] x,
  output logic [S*N-1:0] y,
  output logic           done
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [31:0] Q_ONE     = 32'h0100_0000;
  localparam logic [31:0] Q_FIVE    = 32'h0500_0000;
  localparam logic [31:0] Q_2P375   = 32'h0260_0000;
  localparam logic [31:0] Q_0P84375 = 32'h00D8_0000;
  localparam logic [31:0] Q_0P625   = 32'h00A0_0000;
  localparam logic [31:0] Q_HALF    = 32'h0080_0000;

  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [S*N-1:0] x_q, x_d;
  logic [S*N-1:0] y_d;
  logic           done_d;
  logic [S-1:0]   lane_x, lane_y;

  // One lane: float -> |x| in Q8.24 -> segment -> sign fold -> float.
  function automatic logic [31:0] lane_sigmoid(input logic [31:0] f);
    logic        s;
    logic [7:0]  ef;
    logic [31:0] m, a, p, r;
    logic [24:0] r25, norm;
    logic [4:0]  lead;
    logic [7:0]  eo;
    s    = f[31];
    ef   = f[30:23];
    m    = {8'd0, 1'b1, f[22:0]};
    a    = '0;
    lead = '0;
    // Unbiased e = ef-127: e>=3 (incl. Inf/NaN) saturates, e<=-26 underflows.
    if (ef == 8'd0)         a = '0;
    else if (ef >= 8'd130)  a = Q_FIVE;
    else if (ef >= 8'd126)  a = m << (ef - 8'd126);
    else if (ef <= 8'd101)  a = '0;
    else                    a = m >> (8'd126 - ef);

    if (a >= Q_FIVE)        p = Q_ONE;
    else if (a >= Q_2P375)  p = (a >> 5) + Q_0P84375;
    else if (a >= Q_ONE)    p = (a >> 3) + Q_0P625;
    else                    p = (a >> 2) + Q_HALF;

    r   = s ? (Q_ONE - p) : p;
    r25 = r[24:0];
    for (int k = 0; k < 25; k++) begin
      if (r25[k]) lead = 5'(k);
    end
    norm = r25 << (5'd24 - lead);
    eo   = 8'd103 + {3'd0, lead};
    return (r25 == '0) ? 32'h0 : {1'b0, eo, norm[23:1]};
  endfunction

  always_comb begin
    lane_x = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == idx_q) lane_x = x_q[S*i +: S];
    end
    lane_y = lane_sigmoid(lane_x);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y;
    done_d  = done;
    case (state_q)
      LOAD: begin
        x_d     = x;
        idx_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        for (int i = 0; i < N; i++) begin
          if (IW'(i) == idx_q) y_d[S*i +: S] = lane_y;
        end
        if (idx_q == IW'(N - 1)) begin
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (start) begin
          x_d     = x;
          done_d  = 1'b0;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      x_q     <= '0;
      y       <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y       <= y_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_sigmoid.sv
// Directed bench for sigmoid: hand-computed lane results, reset and
// request-handling corner cases.
module tb_sigmoid;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] x;
  logic [63:0] y;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  sigmoid #(.S(32), .N(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .x    (x),
    .y    (y),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(tag, {63'd0, done}, 64'd1);
  endtask

  task automatic request(input logic [63:0] xv, input string tag, input logic [63:0] yv);
    x     = xv;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_drop"}, {63'd0, done}, 64'd0);
    wait_done({tag, "_done"});
    check({tag, "_y"}, y, yv);
  endtask

  initial begin
    int rises;
    logic prev;
    rst_n = 1'b0;
    start = 1'b1;
    x     = {32'hc0733333, 32'h40a00000};
    #23;
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_y", y, 64'd0);
    start = 1'b0;

    // Release: accepting edge, then one lane per edge.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("lat_e1", {63'd0, done}, 64'd0);
    step();
    check("lat_e2", {63'd0, done}, 64'd0);
    step();
    check("lat_e3", {63'd0, done}, 64'd1);
    check("y_m3p8_5", y, {32'h3D1999A0, 32'h3F800000});
    step();
    check("hold_y", y, {32'h3D1999A0, 32'h3F800000});

    // Second reset-driven computation.
    rst_n = 1'b0;
    x     = {32'h00000000, 32'h40a00000};
    #4;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("r2_done");
    check("y_0_5", y, {32'h3F000000, 32'h3F800000});

    // Request from DONE with exact latency.
    x     = {32'hBF800000, 32'h3F800000};
    start = 1'b1;
    step();
    start = 1'b0;
    check("req_drop", {63'd0, done}, 64'd0);
    step();
    check("req_e2", {63'd0, done}, 64'd0);
    step();
    check("req_e3", {63'd0, done}, 64'd1);
    check("y_m1_1", y, {32'h3E800000, 32'h3F400000});

    request({32'hC0A00000, 32'h3F000000}, "m5_half", {32'h00000000, 32'h3F200000});
    request({32'hFF800000, 32'h7F800000}, "inf", {32'h00000000, 32'h3F800000});
    request({32'hFFC00000, 32'h7FC00000}, "nan", {32'h00000000, 32'h3F800000});
    request({32'h80000001, 32'h33000000}, "tiny", {32'h3F000000, 32'h3F000000});

    // Reset mid-CALC after lane 0 has been written.
    x     = {32'h3F800000, 32'hBF800000};
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_y", y, 64'd0);
    x = {32'h3F000000, 32'h00000000};
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("abort_redo_done");
    check("abort_redo_y", y, {32'h3F200000, 32'h3F000000});

    // start held through CALC is ignored: one done rise only.
    rises = 0;
    prev  = done;
    x     = {32'hC0A00000, 32'h40a00000};
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (done && !prev) rises++;
      prev = done;
    end
    check("one_rise", 64'(rises), 64'd1);
    check("ign_y", y, {32'h00000000, 32'h3F800000});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
